// File: rtl/blu_inv_butterfly.sv
// blu_inv_butterfly: inverse-NTT (Gentleman-Sande) butterfly, two lanes.
//   a' = (a+b) mod Q, b' = ((a-b)*zeta) mod Q, 4-stage valid/ready pipe.
// Ports:
//   clk_i, reset_i (sync, active-high)
//   data1_i/data2_i : packed a/b lanes, lane0 in the low half
//   zeta_i          : twiddle shared by both lanes
//   valid_i/ready_o : input handshake
//   data1_o/data2_o : packed a'/b' lanes
//   valid_o/ready_i : output handshake
// Option: define BLU_INTT_HALF_SCALE_EN to scale both outputs by 2^-1 mod Q.
module blu_inv_butterfly #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned Q          = 8380417
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic [DATA_WIDTH-1:0]   data1_i,
    input  logic [DATA_WIDTH-1:0]   data2_i,
    input  logic [DATA_WIDTH/2-1:0] zeta_i,
    input  logic                    valid_i,
    output logic                    ready_o,
    output logic [DATA_WIDTH-1:0]   data1_o,
    output logic [DATA_WIDTH-1:0]   data2_o,
    output logic                    valid_o,
    input  logic                    ready_i
);
    localparam int unsigned LANE_W = DATA_WIDTH / 2;
    localparam int unsigned PW     = 2 * LANE_W;

    localparam logic [LANE_W-1:0] QL = LANE_W'(Q);
    localparam logic [PW-1:0]     QP = PW'(Q);

    // Barrett constant floor(2^PW / Q). Products are < 2^(2*LANE_W-2), so the
    // quotient estimate is low by at most one and a single subtract suffices.
    localparam logic [PW:0]   BASE = {1'b1, {PW{1'b0}}};
    localparam logic [PW-1:0] MU   = PW'(BASE / (PW+1)'(Q));

    typedef logic [1:0][LANE_W-1:0] lanes_t;
    typedef logic [1:0][PW-1:0]     prods_t;

    logic adv;

    // S1
    logic              v1_q;
    lanes_t            s1_q, d1_q;
    logic [LANE_W-1:0] z1_q;
    // S2
    logic              v2_q;
    lanes_t            s2_q;
    prods_t            p2_q;
    // S3
    logic              v3_q;
    lanes_t            s3_q, r3_q;
    // S4
    logic              v4_q;
    lanes_t            o1_q, o2_q;

    lanes_t a, b;
    lanes_t s1_d, d1_d, r3_d, o1_d, o2_d;
    prods_t p2_d;

    logic [LANE_W:0] sum;
    logic [PW-1:0]   qhat, rem;

`ifdef BLU_INTT_HALF_SCALE_EN
    // Multiply by 2^-1 mod Q: odd values borrow one Q to become even.
    function automatic logic [LANE_W-1:0] half(input logic [LANE_W-1:0] x);
        if (x[0])
            return LANE_W'(({1'b0, x} + {1'b0, QL}) >> 1);
        return x >> 1;
    endfunction
`endif

    assign adv     = ready_i | ~valid_o;
    assign ready_o = adv;
    assign valid_o = v4_q;
    assign data1_o = o1_q;
    assign data2_o = o2_q;
    assign a       = data1_i;
    assign b       = data2_i;

    always_comb begin
        s1_d = '0;
        d1_d = '0;
        p2_d = '0;
        r3_d = '0;
        o1_d = '0;
        o2_d = '0;
        sum  = '0;
        qhat = '0;
        rem  = '0;
        for (int i = 0; i < 2; i++) begin
            sum = {1'b0, a[i]} + {1'b0, b[i]};
            if (sum >= {1'b0, QL})
                sum = sum - {1'b0, QL};
            s1_d[i] = LANE_W'(sum);
            d1_d[i] = a[i] - b[i];
            if (a[i] < b[i])
                d1_d[i] = d1_d[i] + QL;

            p2_d[i] = {{LANE_W{1'b0}}, d1_q[i]} * {{LANE_W{1'b0}}, z1_q};

            qhat = PW'(({{PW{1'b0}}, p2_q[i]} * {{PW{1'b0}}, MU}) >> PW);
            rem  = p2_q[i] - PW'(qhat * QP);
            if (rem >= QP)
                rem = rem - QP;
            r3_d[i] = LANE_W'(rem);

`ifdef BLU_INTT_HALF_SCALE_EN
            o1_d[i] = half(s3_q[i]);
            o2_d[i] = half(r3_q[i]);
`else
            o1_d[i] = s3_q[i];
            o2_d[i] = r3_q[i];
`endif
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
            v3_q <= 1'b0;
            v4_q <= 1'b0;
            o1_q <= '0;
            o2_q <= '0;
        end else if (adv) begin
            v1_q <= valid_i;
            s1_q <= s1_d;
            d1_q <= d1_d;
            z1_q <= zeta_i;
            v2_q <= v1_q;
            s2_q <= s1_q;
            p2_q <= p2_d;
            v3_q <= v2_q;
            s3_q <= s2_q;
            r3_q <= r3_d;
            v4_q <= v3_q;
            o1_q <= o1_d;
            o2_q <= o2_d;
        end
    end

endmodule

// File: tb/tb_blu_inv_butterfly.sv
// tb_blu_inv_butterfly: directed and random checks of blu_inv_butterfly
//   against a queue-based arithmetic reference model.
module tb_blu_inv_butterfly;
    localparam int     DW = 64;
    localparam int     LW = 32;
    localparam longint Q  = 8380417;

`ifdef BLU_INTT_HALF_SCALE_EN
    localparam logic [31:0] E_S1 = 4;
    localparam logic [31:0] E_D1 = 1;
    localparam logic [31:0] E_S2 = 4;
    localparam logic [31:0] E_D2 = 8380415;
    localparam logic [31:0] E_S3 = 0;
    localparam logic [31:0] E_D3 = 8380416;
    localparam logic [31:0] E_L0 = 2;
    localparam logic [31:0] E_L1 = 8380415;
`else
    localparam logic [31:0] E_S1 = 8;
    localparam logic [31:0] E_D1 = 2;
    localparam logic [31:0] E_S2 = 8;
    localparam logic [31:0] E_D2 = 8380413;
    localparam logic [31:0] E_S3 = 0;
    localparam logic [31:0] E_D3 = 8380415;
    localparam logic [31:0] E_L0 = 4;
    localparam logic [31:0] E_L1 = 8380413;
`endif

    logic          clk = 1'b0;
    logic          reset_i, valid_i, ready_i, ready_o, valid_o;
    logic [DW-1:0] data1_i, data2_i, data1_o, data2_o;
    logic [LW-1:0] zeta_i;

    always #5 clk = ~clk;

    blu_inv_butterfly #(.DATA_WIDTH(DW), .Q(32'(Q))) dut (
        .clk_i   (clk),
        .reset_i (reset_i),
        .data1_i (data1_i),
        .data2_i (data2_i),
        .zeta_i  (zeta_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .data1_o (data1_o),
        .data2_o (data2_o),
        .valid_o (valid_o),
        .ready_i (ready_i)
    );

    typedef struct {
        logic [63:0] d1;
        logic [63:0] d2;
        int          acc;
        int          st;
    } exp_t;

    exp_t        q[$];
    int          total = 0;
    int          bad = 0;
    int          cyc_n = 0;
    int          stall_n = 0;
    logic [63:0] last1, last2, hold1, hold2;
    bit          holding = 0;

    function automatic longint halve(input longint x);
`ifdef BLU_INTT_HALF_SCALE_EN
        return (x % 2 == 1) ? (x + Q) / 2 : x / 2;
`else
        return x;
`endif
    endfunction

    function automatic logic [31:0] m_add(input longint a, input longint b);
        return 32'(halve((a + b) % Q));
    endfunction

    function automatic logic [31:0] m_sub(input longint a, input longint b,
                                          input longint z);
        return 32'(halve(((a - b + Q) * z) % Q));
    endfunction

    function automatic logic [31:0] rnd_lane();
        int unsigned k;
        k = $urandom_range(15, 0);
        if (k == 0) return 32'd0;
        if (k == 1) return 32'(Q - 1);
        return 32'($urandom_range(32'(Q - 1), 0));
    endfunction

    task automatic cyc(input bit v, input logic [63:0] a, input logic [63:0] b,
                       input logic [31:0] z, input bit r, output bit acc);
        exp_t e;
        int   lat;
        @(negedge clk);
        reset_i = 1'b0;
        valid_i = v;
        data1_i = a;
        data2_i = b;
        zeta_i  = z;
        ready_i = r;
        #1;
        total++;
        assert (ready_o === (ready_i | ~valid_o)) else begin
            bad++;
            $error("FAIL ready_o obs=%b exp=%b", ready_o, ready_i | ~valid_o);
        end
        if (holding) begin
            total++;
            assert ({valid_o, data1_o, data2_o} === {1'b1, hold1, hold2}) else begin
                bad++;
                $error("FAIL stall_hold obs=%b/%h/%h exp=1/%h/%h",
                       valid_o, data1_o, data2_o, hold1, hold2);
            end
        end
        holding = (valid_o === 1'b1) && !r;
        hold1   = data1_o;
        hold2   = data2_o;
        if (valid_o === 1'b1 && r) begin
            total++;
            assert (q.size() != 0) else begin
                bad++;
                $error("FAIL spurious_beat obs=%h/%h exp=none", data1_o, data2_o);
            end
            if (q.size() != 0) begin
                e = q.pop_front();
                last1 = data1_o;
                last2 = data2_o;
                total++;
                assert (data1_o === e.d1) else begin
                    bad++;
                    $error("FAIL data1 obs=%h exp=%h", data1_o, e.d1);
                end
                total++;
                assert (data2_o === e.d2) else begin
                    bad++;
                    $error("FAIL data2 obs=%h exp=%h", data2_o, e.d2);
                end
                lat = (cyc_n - e.acc) - (stall_n - e.st);
                total++;
                assert (lat == 4) else begin
                    bad++;
                    $error("FAIL latency obs=%0d exp=4", lat);
                end
            end
        end
        acc = v && (ready_o === 1'b1);
        if (acc) begin
            e.d1  = {m_add(a[63:32], b[63:32]), m_add(a[31:0], b[31:0])};
            e.d2  = {m_sub(a[63:32], b[63:32], z), m_sub(a[31:0], b[31:0], z)};
            e.acc = cyc_n;
            e.st  = stall_n;
            q.push_back(e);
        end
        if (ready_o !== 1'b1) stall_n++;
        cyc_n++;
    endtask

    task automatic rst();
        @(negedge clk);
        reset_i = 1'b1;
        valid_i = 1'b0;
        ready_i = 1'b1;
        @(negedge clk);
        reset_i = 1'b0;
        q.delete();
        holding = 0;
        #1;
        total++;
        assert ({valid_o, ready_o, data1_o, data2_o} === {2'b01, 128'd0}) else begin
            bad++;
            $error("FAIL reset_state obs=%b/%b/%h/%h exp=0/1/0/0",
                   valid_o, ready_o, data1_o, data2_o);
        end
        cyc_n++;
    endtask

    task automatic drain(input int budget);
        bit acc;
        for (int i = 0; i < budget && q.size() != 0; i++)
            cyc(0, '0, '0, '0, 1, acc);
        total++;
        assert (q.size() == 0) else begin
            bad++;
            $error("FAIL drain_timeout obs=%0d exp=0", q.size());
        end
    endtask

    task automatic check_lane(input string tag, input logic [31:0] obs,
                              input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s obs=%0d exp=%0d", tag, obs, expv);
        end
    endtask

    initial begin
        bit acc;
        int sent, k;
        reset_i = 1'b1;
        valid_i = 1'b0;
        ready_i = 1'b1;
        data1_i = '0;
        data2_i = '0;
        zeta_i  = '0;
        repeat (2) @(posedge clk);
        rst();

        cyc(1, {32'd0, 32'd5}, {32'd0, 32'd3}, 32'd1, 1, acc);
        drain(10);
        check_lane("single_a", last1[31:0], E_S1);
        check_lane("single_b", last2[31:0], E_D1);

        cyc(1, {32'd0, 32'd3}, {32'd0, 32'd5}, 32'd2, 1, acc);
        drain(10);
        check_lane("wrap_a", last1[31:0], E_S2);
        check_lane("wrap_b", last2[31:0], E_D2);

        cyc(1, {32'd0, 32'(Q - 1)}, {32'd0, 32'd1}, 32'd1, 1, acc);
        drain(10);
        check_lane("qm1_a", last1[31:0], E_S3);
        check_lane("qm1_b", last2[31:0], E_D3);

        cyc(1, {32'd3, 32'd5}, {32'd5, 32'd3}, 32'd2, 1, acc);
        drain(10);
        check_lane("lane0_a", last1[31:0], E_S1);
        check_lane("lane1_a", last1[63:32], E_S1);
        check_lane("lane0_b", last2[31:0], E_L0);
        check_lane("lane1_b", last2[63:32], E_L1);

        sent = 0;
        k = 0;
        while (sent < 10 && k < 200) begin
            cyc(1, {rnd_lane(), rnd_lane()}, {rnd_lane(), rnd_lane()},
                rnd_lane(), (k % 3) == 0, acc);
            if (acc) sent++;
            k++;
        end
        for (int i = 0; i < 12; i++)
            cyc(0, '0, '0, '0, (i % 3) == 0, acc);
        drain(20);

        for (int i = 0; i < 3; i++)
            cyc(1, {rnd_lane(), rnd_lane()}, {rnd_lane(), rnd_lane()},
                rnd_lane(), 1, acc);
        rst();
        for (int i = 0; i < 8; i++)
            cyc(0, '0, '0, '0, 1, acc);

        sent = 0;
        k = 0;
        while (sent < 10000 && k < 40000) begin
            cyc($urandom_range(3, 0) != 0, {rnd_lane(), rnd_lane()},
                {rnd_lane(), rnd_lane()}, rnd_lane(),
                $urandom_range(9, 0) < 7, acc);
            if (acc) sent++;
            k++;
        end
        total++;
        assert (sent == 10000) else begin
            bad++;
            $error("FAIL random_accept obs=%0d exp=10000", sent);
        end
        drain(50);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
